// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: one single-port memory shared by the fetch and data ports.
// Requests are arbitrated in IDLE and sequenced over a fixed read latency.
module unified_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  output logic          i_stall,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_stall,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic [1:0]    dbgState
);
  // Handshake: a requester raises req with address/data stable and holds them until its
  // valid pulses for exactly one cycle; stall = req & ~valid. Requests are sampled only in IDLE.

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  stateT          state;
  stateT          nextState;
  logic           ownerData;
  logic           ownerStore;
  logic [CW-1:0]  waitCnt;
  logic [SW-1:0]  starveCnt;
  logic           anyReq;
  logic           grantData;

  always_comb begin
    anyReq    = i_req | d_req;
    grantData = d_req;
    // On a conflict data wins until the fetch port has lost STARVE_MAX times in a row.
    if (i_req && d_req) grantData = (starveCnt != SW'(STARVE_MAX));
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ISSUE;
      ISSUE:   nextState = ownerStore ? RESP : WAIT;
      WAIT:    if (waitCnt == CW'(1)) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign m_en     = (state == ISSUE);
  assign m_we     = m_en & ownerStore;
  assign i_valid  = (state == RESP) & ~ownerData;
  assign d_valid  = (state == RESP) & ownerData;
  assign i_stall  = i_req & ~i_valid;
  assign d_stall  = d_req & ~d_valid;
  assign dbgState = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ownerData  <= 1'b0;
      ownerStore <= 1'b0;
      waitCnt    <= '0;
      starveCnt  <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (anyReq) begin
            ownerData  <= grantData;
            ownerStore <= grantData & d_we;
            m_addr     <= grantData ? d_addr : i_addr;
            if (grantData) m_wdata <= d_wdata;
            // A data win over a waiting fetch is always below the cap, so no saturation test.
            if (!grantData) starveCnt <= '0;
            else if (i_req) starveCnt <= starveCnt + SW'(1);
          end
        end
        ISSUE: waitCnt <= CW'(MEM_LAT);
        WAIT: begin
          waitCnt <= waitCnt - CW'(1);
          if (waitCnt == CW'(1)) begin
            if (ownerData) d_rdata <= m_rdata;
            else           i_rdata <= m_rdata;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: two instances (read latency 1 and 3) against a
// latency-accurate memory model and a transaction-level reference of the arbitration rules.
module tb_unified_mem_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    [2];
  logic        iReq   [2];
  logic        dReq   [2];
  logic        dWe    [2];
  logic [31:0] iAddr  [2];
  logic [31:0] dAddr  [2];
  logic [31:0] dWdata [2];
  logic [31:0] iRdata [2];
  logic [31:0] dRdata [2];
  logic [31:0] mAddr  [2];
  logic [31:0] mWdata [2];
  logic [31:0] mRdata [2];
  logic        iValid [2];
  logic        iStall [2];
  logic        dValid [2];
  logic        dStall [2];
  logic        mEn    [2];
  logic        mWe    [2];
  logic [1:0]  dbg    [2];

  for (genvar g = 0; g < 2; g++) begin : gDut
    unified_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(g == 0 ? 1 : 3), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst[g]),
      .i_req(iReq[g]), .i_addr(iAddr[g]), .i_rdata(iRdata[g]), .i_valid(iValid[g]), .i_stall(iStall[g]),
      .d_req(dReq[g]), .d_we(dWe[g]), .d_addr(dAddr[g]), .d_wdata(dWdata[g]),
      .d_rdata(dRdata[g]), .d_valid(dValid[g]), .d_stall(dStall[g]),
      .m_en(mEn[g]), .m_we(mWe[g]), .m_addr(mAddr[g]), .m_wdata(mWdata[g]), .m_rdata(mRdata[g]),
      .dbgState(dbg[g])
    );
  end

  function automatic int lat(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  // Memory model: read data is valid only in the single cycle MEM_LAT after m_en, junk otherwise.
  logic [31:0] mem   [2][256];
  logic [31:0] pipeD [2][3];
  logic        pipeV [2][3];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      for (int s = 2; s > 0; s--) begin
        pipeD[g][s] <= pipeD[g][s-1];
        pipeV[g][s] <= pipeV[g][s-1];
      end
      pipeV[g][0] <= (mEn[g] === 1'b1) && (mWe[g] === 1'b0);
      pipeD[g][0] <= mem[g][mAddr[g][7:0]];
      if (mEn[g] === 1'b1 && mWe[g] === 1'b1) mem[g][mAddr[g][7:0]] = mWdata[g];
    end
  end

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      mRdata[g] = (pipeV[g][lat(g)-1] === 1'b1) ? pipeD[g][lat(g)-1] : (32'hA5A5_5A5A ^ g);
    end
  end

  // Reference model: architectural memory contents and consecutive fetch losses per instance.
  logic [31:0] refMem [2][256];
  int          starve [2];
  int          checks   = 0;
  int          failures = 0;

  task automatic run_txn(input int idx, input bit iOn, input bit dOn, input bit we,
                         input logic [7:0] ia, input logic [7:0] da, input logic [31:0] wd,
                         input bit keepLoser);
    bit          firstD, expI, expD, doneI, doneD, own;
    int          kI, kD, iLat, dLat;
    bit          ownQ[$];
    logic [31:0] prevD;
    iLat  = 2 + lat(idx);
    dLat  = we ? 2 : 2 + lat(idx);
    firstD = (iOn && dOn) ? (starve[idx] != SMAX) : dOn;
    doneI = 0; doneD = 0;
    if (firstD) begin
      expD = 1; kD = dLat; ownQ.push_back(1'b1);
      if (iOn) starve[idx] = (starve[idx] < SMAX) ? starve[idx] + 1 : SMAX;
      expI = iOn && keepLoser; kI = kD + 1 + iLat;
      if (expI) begin ownQ.push_back(1'b0); starve[idx] = 0; end
    end else begin
      expI = 1; kI = iLat; ownQ.push_back(1'b0); starve[idx] = 0;
      expD = dOn && keepLoser; kD = kI + 1 + dLat;
      if (expD) ownQ.push_back(1'b1);
    end
    prevD = dRdata[idx];
    iReq[idx] = iOn; iAddr[idx] = {24'h0, ia};
    dReq[idx] = dOn; dWe[idx] = we; dAddr[idx] = {24'h0, da}; dWdata[idx] = wd;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      checks += 3;
      if (iStall[idx] !== (iReq[idx] & ~iValid[idx])) begin
        failures++; $display("FAIL i_stall inst=%0d k=%0d got=%b want=%b", idx, k, iStall[idx], iReq[idx] & ~iValid[idx]);
      end
      if (dStall[idx] !== (dReq[idx] & ~dValid[idx])) begin
        failures++; $display("FAIL d_stall inst=%0d k=%0d got=%b want=%b", idx, k, dStall[idx], dReq[idx] & ~dValid[idx]);
      end
      if (iValid[idx] === 1'b1 && dValid[idx] === 1'b1) begin
        failures++; $display("FAIL dual_valid inst=%0d k=%0d got=both want=one", idx, k);
      end
      if (mEn[idx] === 1'b1) begin
        checks += 2;
        if (ownQ.size() == 0) begin
          failures += 2; $display("FAIL extra_m_en inst=%0d k=%0d got=1 want=0", idx, k);
        end else begin
          own = ownQ.pop_front();
          if (mAddr[idx] !== (own ? {24'h0, da} : {24'h0, ia})) begin
            failures++; $display("FAIL m_addr inst=%0d k=%0d got=%h want=%h", idx, k, mAddr[idx], own ? da : ia);
          end
          if (mWe[idx] !== (own & we)) begin
            failures++; $display("FAIL m_we inst=%0d k=%0d got=%b want=%b", idx, k, mWe[idx], own & we);
          end
          if (own && we) begin
            checks++;
            if (mWdata[idx] !== wd) begin
              failures++; $display("FAIL m_wdata inst=%0d got=%h want=%h", idx, mWdata[idx], wd);
            end
          end
        end
      end else begin
        checks++;
        if (mWe[idx] !== 1'b0) begin
          failures++; $display("FAIL m_we_idle inst=%0d k=%0d got=%b want=0", idx, k, mWe[idx]);
        end
      end
      if (iValid[idx] === 1'b1) begin
        checks += 2;
        if (!expI || doneI || k != kI) begin
          failures++; $display("FAIL i_valid_time inst=%0d got=%0d want=%0d", idx, k, expI ? kI : -1);
        end
        if (iRdata[idx] !== refMem[idx][ia]) begin
          failures++; $display("FAIL i_rdata inst=%0d got=%h want=%h", idx, iRdata[idx], refMem[idx][ia]);
        end
        doneI = 1; iReq[idx] = 1'b0;
        if (!keepLoser) dReq[idx] = 1'b0;
      end
      if (dValid[idx] === 1'b1) begin
        checks += 2;
        if (!expD || doneD || k != kD) begin
          failures++; $display("FAIL d_valid_time inst=%0d got=%0d want=%0d", idx, k, expD ? kD : -1);
        end
        if (we) begin
          if (dRdata[idx] !== prevD) begin
            failures++; $display("FAIL d_rdata_store inst=%0d got=%h want=%h", idx, dRdata[idx], prevD);
          end
          refMem[idx][da] = wd;
        end else if (dRdata[idx] !== refMem[idx][da]) begin
          failures++; $display("FAIL d_rdata inst=%0d got=%h want=%h", idx, dRdata[idx], refMem[idx][da]);
        end
        doneD = 1; dReq[idx] = 1'b0;
        if (!keepLoser) iReq[idx] = 1'b0;
      end
      if ((doneI || !expI) && (doneD || !expD)) break;
    end
    checks++;
    if (!((doneI || !expI) && (doneD || !expD))) begin
      failures++; $display("FAIL txn_timeout inst=%0d got=done_i%0b_d%0b want=complete", idx, doneI, doneD);
    end
    iReq[idx] = 1'b0; dReq[idx] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({iValid[idx], dValid[idx], mEn[idx]} !== 3'b000) begin
        failures++; $display("FAIL trailing inst=%0d got=%b want=000", idx, {iValid[idx], dValid[idx], mEn[idx]});
      end
    end
  endtask

  task automatic test_reset();
    for (int g = 0; g < 2; g++) begin
      checks += 5;
      if ({mEn[g], mWe[g], iValid[g], dValid[g], iStall[g], dStall[g]} !== 6'b0) begin
        failures++; $display("FAIL reset_ctrl inst=%0d got=%b want=000000", g,
                             {mEn[g], mWe[g], iValid[g], dValid[g], iStall[g], dStall[g]});
      end
      if (mAddr[g] !== 32'h0)  begin failures++; $display("FAIL reset_m_addr inst=%0d got=%h want=0", g, mAddr[g]); end
      if (mWdata[g] !== 32'h0) begin failures++; $display("FAIL reset_m_wdata inst=%0d got=%h want=0", g, mWdata[g]); end
      if (iRdata[g] !== 32'h0) begin failures++; $display("FAIL reset_i_rdata inst=%0d got=%h want=0", g, iRdata[g]); end
      if (dRdata[g] !== 32'h0) begin failures++; $display("FAIL reset_d_rdata inst=%0d got=%h want=0", g, dRdata[g]); end
    end
  endtask

  task automatic test_fetch();
    run_txn(0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h00, 32'h0, 1'b0);
    checks++;
    if (iRdata[0] !== 32'h0050_0113) begin
      failures++; $display("FAIL fetch_hold got=%h want=00500113", iRdata[0]);
    end
  endtask

  task automatic test_store_load();
    run_txn(0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h40, 32'hDEAD_BEEF, 1'b0);
    run_txn(0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 32'h0, 1'b0);
    checks++;
    if (dRdata[0] !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL store_load got=%h want=deadbeef", dRdata[0]);
    end
  endtask

  task automatic test_starvation(input int idx);
    bit expOrder[10];
    int n, last;
    run_txn(idx, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (starve[idx] == SMAX) begin expOrder[i] = 1'b0; starve[idx] = 0; end
      else begin expOrder[i] = 1'b1; starve[idx]++; end
    end
    iReq[idx] = 1'b1; iAddr[idx] = 32'h20;
    dReq[idx] = 1'b1; dWe[idx] = 1'b0; dAddr[idx] = 32'h30;
    n = 0; last = 0;
    for (int c = 0; c < 300 && n < 10; c++) begin
      @(negedge clk);
      checks++;
      if (iValid[idx] === 1'b1 && dValid[idx] === 1'b1) begin
        failures++; $display("FAIL starve_dual inst=%0d cycle=%0d got=both want=one", idx, c);
      end
      if (iValid[idx] === 1'b1 || dValid[idx] === 1'b1) begin
        checks += 2;
        if (dValid[idx] !== expOrder[n]) begin
          failures++; $display("FAIL grant_order n=%0d got=%s want=%s", n, dValid[idx] ? "D" : "I", expOrder[n] ? "D" : "I");
        end
        if (dValid[idx] === 1'b1 ? (dRdata[idx] !== refMem[idx][8'h30]) : (iRdata[idx] !== refMem[idx][8'h20])) begin
          failures++; $display("FAIL starve_data n=%0d got=%h/%h want=%h/%h", n, iRdata[idx], dRdata[idx],
                               refMem[idx][8'h20], refMem[idx][8'h30]);
        end
        if (n > 0) begin
          checks++;
          if (c - last != 3 + lat(idx)) begin
            failures++; $display("FAIL read_throughput n=%0d got=%0d want=%0d", n, c - last, 3 + lat(idx));
          end
        end
        last = c; n++;
        if (n == 10) begin iReq[idx] = 1'b0; dReq[idx] = 1'b0; end
      end
    end
    checks++;
    if (n != 10) begin
      failures++; $display("FAIL starve_timeout got=%0d want=10", n);
    end
    iReq[idx] = 1'b0; dReq[idx] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lat3();
    run_txn(1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h44, 32'h0, 1'b0);
    run_txn(1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h48, 32'h1234_5678, 1'b0);
    run_txn(1, 1'b1, 1'b0, 1'b0, 8'h48, 8'h00, 32'h0, 1'b0);
  endtask

  task automatic test_drop_req(input int idx);
    int got;
    dReq[idx] = 1'b1; dWe[idx] = 1'b0; dAddr[idx] = 32'h60;
    @(negedge clk);
    checks++;
    if (mEn[idx] !== 1'b1) begin
      failures++; $display("FAIL drop_m_en inst=%0d got=%b want=1", idx, mEn[idx]);
    end
    dReq[idx] = 1'b0;
    got = -1;
    for (int k = 2; k <= 12 && got < 0; k++) begin
      @(negedge clk);
      if (dValid[idx] === 1'b1) got = k;
    end
    checks += 2;
    if (got != 2 + lat(idx)) begin
      failures++; $display("FAIL drop_valid inst=%0d got=%0d want=%0d", idx, got, 2 + lat(idx));
    end
    if (dRdata[idx] !== refMem[idx][8'h60]) begin
      failures++; $display("FAIL drop_data inst=%0d got=%h want=%h", idx, dRdata[idx], refMem[idx][8'h60]);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid(input int idx);
    iReq[idx] = 1'b0;
    dReq[idx] = 1'b1; dWe[idx] = 1'b0; dAddr[idx] = 32'h50;
    repeat (3) @(negedge clk);
    rst[idx] = 1'b1;
    #1;
    checks += 3;
    if ({mEn[idx], mWe[idx], dValid[idx], dStall[idx]} !== 4'b0001) begin
      failures++; $display("FAIL rst_mid_ctrl inst=%0d got=%b want=0001", idx, {mEn[idx], mWe[idx], dValid[idx], dStall[idx]});
    end
    if (dRdata[idx] !== 32'h0) begin
      failures++; $display("FAIL rst_mid_d_rdata inst=%0d got=%h want=0", idx, dRdata[idx]);
    end
    if (mAddr[idx] !== 32'h0) begin
      failures++; $display("FAIL rst_mid_m_addr inst=%0d got=%h want=0", idx, mAddr[idx]);
    end
    starve[idx] = 0;
    @(negedge clk);
    checks++;
    if (dValid[idx] !== 1'b0) begin
      failures++; $display("FAIL rst_mid_valid inst=%0d got=%b want=0", idx, dValid[idx]);
    end
    rst[idx] = 1'b0;
    run_txn(idx, 1'b0, 1'b1, 1'b0, 8'h00, 8'h50, 32'h0, 1'b0);
  endtask

  task automatic test_random(input int n);
    int idx, r;
    for (int t = 0; t < n; t++) begin
      idx = $urandom_range(0, 1);
      r   = $urandom_range(0, 5);
      run_txn(idx, r != 2, r >= 2, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), $urandom, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    for (int g = 0; g < 2; g++) begin
      rst[g] = 1'b1; iReq[g] = 1'b0; dReq[g] = 1'b0; dWe[g] = 1'b0;
      iAddr[g] = '0; dAddr[g] = '0; dWdata[g] = '0; starve[g] = 0;
      for (int a = 0; a < 256; a++) begin
        v = $urandom;
        mem[g][a] = v; refMem[g][a] = v;
      end
    end
    mem[0][8'h10] = 32'h0050_0113; refMem[0][8'h10] = 32'h0050_0113;
    repeat (3) @(negedge clk);
    test_reset();
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_store_load();
    test_starvation(0);
    test_lat3();
    test_starvation(1);
    test_drop_req(0);
    test_drop_req(1);
    test_reset_mid(1);
    test_random(60);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
